pipelined_addsub: RTL

//  Parametrised, pipelined two's-complement adder/subtractor; next generation of the 32-bit ripple adder.

---
 rtl/pipelined_addsub_pkg.sv | 21 ++
 rtl/pipelined_addsub_segment.sv | 39 +++
 rtl/pipelined_addsub.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_pkg
// Brief    : Shared operation codes and 1-bit full-adder helper for the
//            pipelined add/sub datapath.
// Revision : 1.0 - initial release
// ============================================================================
package pipelined_addsub_pkg;

  typedef enum logic [0:0] {
    c_op_add = 1'b0,
    c_op_sub = 1'b1
  } op_e;

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_addsub_segment.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_segment
// Brief    : Combinational SEG-bit ripple adder built from the 1-bit full adder;
//            also exposes the carry into its most significant bit.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub_segment
  import pipelined_addsub_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic       w_c;
  logic [1:0] w_fa;

  always_comb begin
    w_c  = cin;
    w_fa = 2'b00;
    cmsb = cin;
    sum  = '0;
    for (int i = 0; i < SEG; i++) begin
      cmsb   = w_c;
      w_fa   = full_add(a[i], b[i], w_c);
      sum[i] = w_fa[0];
      w_c    = w_fa[1];
    end
    cout = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Brief    : Pipelined two's-complement adder/subtractor, one carry segment per
//            register stage, valid/ready on both sides with a global stall.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES (1..WIDTH)");
    end
  endgenerate

  logic              w_advance;
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [STAGES-1:0] r_cmsb;
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_bx  [STAGES];
  logic              r_zero;

  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_cmsb;
  logic [WIDTH-1:0]  w_ain   [STAGES];
  logic [WIDTH-1:0]  w_bin   [STAGES];
  logic [WIDTH-1:0]  w_sin   [STAGES];
  logic [WIDTH-1:0]  w_snext [STAGES];
  logic [SEG-1:0]    w_seg_sum [STAGES];

  assign w_advance = !r_valid[LAST] || out_ready;
  assign in_ready  = w_advance;

  // Stage 0 takes the raw op (subtract folded into ~b and carry 1); later
  // stages take the skewed operands and carry from the previous register.
  always_comb begin
    w_vin[0] = in_valid;
    w_ain[0] = in_a;
    w_bin[0] = (in_sub == c_op_sub) ? ~in_b : in_b;
    w_cin[0] = (in_sub == c_op_sub) ? 1'b1 : carryin;
    w_sin[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k] = r_valid[k-1];
      w_ain[k] = r_a[k-1];
      w_bin[k] = r_bx[k-1];
      w_cin[k] = r_carry[k-1];
      w_sin[k] = r_sum[k-1];
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipelined_addsub_segment #(
        .SEG (SEG)
      ) u_seg (
        .a    (w_ain[k][k*SEG +: SEG]),
        .b    (w_bin[k][k*SEG +: SEG]),
        .cin  (w_cin[k]),
        .sum  (w_seg_sum[k]),
        .cout (w_cout[k]),
        .cmsb (w_cmsb[k])
      );
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_snext[k]                = w_sin[k];
      w_snext[k][k*SEG +: SEG]  = w_seg_sum[k];
    end
  end

  // Whole pipeline holds on a stall; data only loads behind a valid op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_carry <= '0;
      r_cmsb  <= '0;
      r_zero  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_bx[k]  <= '0;
      end
    end else if (w_advance) begin
      r_valid <= w_vin;
      for (int k = 0; k < STAGES; k++) begin
        if (w_vin[k]) begin
          r_sum[k]   <= w_snext[k];
          r_carry[k] <= w_cout[k];
          r_cmsb[k]  <= w_cmsb[k];
          r_a[k]     <= w_ain[k];
          r_bx[k]    <= w_bin[k];
        end
      end
      if (w_vin[LAST]) begin
        r_zero <= (w_snext[LAST] == '0);
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign carryout  = r_carry[LAST];
  assign overflow  = r_cmsb[LAST] ^ r_carry[LAST];
  assign zero      = r_zero;

endmodule
`default_nettype wire
